// File: rtl/s_pipe_skid_reg_if.sv
// Valid/ready handshake bundle for s_pipe_skid_reg: upstream (in_*) and downstream (out_*) sides.
// slave = the pipeline stage's view; master = the surrounding environment's view.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface s_pipe_skid_reg_if #(
    parameter int unsigned DATA_WIDTH = `WORD_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/s_pipe_skid_reg.sv
// Elastic valid/ready pipeline stage with a 2-entry skid buffer, flush-to-bubble and hold.
// Optional S_PIPE_SKID_STALL_CNT_EN adds stall_cnt (saturating stall counter) and skid_active.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module s_pipe_skid_reg #(
    parameter int unsigned DATA_WIDTH   = `WORD_WIDTH,
    parameter bit          BUBBLE_VALID = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  hold_i,
    input  logic [DATA_WIDTH-1:0] bubble_i,
`ifdef S_PIPE_SKID_STALL_CNT_EN
    output logic [31:0]           stall_cnt,
    output logic                  skid_active,
`endif
    s_pipe_skid_reg_if.slave      pipe
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b11
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  main_v;
    logic                  in_fire;
    logic                  out_fire;
    logic                  state_legal;

    // Ready depends only on registered state plus the stage's own control inputs.
    assign main_v        = (state == FULL) || (state == SKID);
    assign state_legal   = (state == EMPTY) || (state == FULL) || (state == SKID);
    assign pipe.in_ready = (state != SKID) && !hold_i && !flush_i;
    assign pipe.out_valid = main_v && !hold_i;
    assign pipe.out_data = main_q;

    assign in_fire  = pipe.in_valid && pipe.in_ready;
    assign out_fire = pipe.out_valid && pipe.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush_i) begin
            state  <= BUBBLE_VALID ? FULL : EMPTY;
            main_q <= bubble_i;
        end else if (!state_legal) begin
            state <= EMPTY;
        end else if (!hold_i) begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state  <= FULL;
                        main_q <= pipe.in_data;
                    end
                end
                FULL: begin
                    case ({in_fire, out_fire})
                        2'b11: main_q <= pipe.in_data;
                        2'b01: state  <= EMPTY;
                        2'b10: begin
                            state  <= SKID;
                            skid_q <= pipe.in_data;
                        end
                        default: ;
                    endcase
                end
                SKID: begin
                    if (out_fire) begin
                        state  <= FULL;
                        main_q <= skid_q;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef S_PIPE_SKID_STALL_CNT_EN
    assign skid_active = (state == SKID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (flush_i) begin
            stall_cnt <= '0;
        end else if (main_v && !pipe.out_ready && !hold_i && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
